m26_rx_ch_frame: RTL and testbench
==================================

# m26_rx_ch_frame

Parametrised Mimosa26-style serial receiver channel with a frame state machine. It deserialises one `DATA_RX` lane framed by the `MKD_RX` marker and emits whole words with frame-start and frame-end strobes. It also checks the frame length field, aborts on an oversize length, and keeps frame and error counters. One instance sits per sensor data lane, between the LVDS input stage and the channel FIFO/arbiter of the `m26_rx` core.

## Interface
- `WORD_WIDTH`, 16: bits per serial word; ≥ 8.
- `MKD_LEN`, 4: consecutive marker samples that identify a frame start; 1 ≤ MKD_LEN < WORD_WIDTH.
- `MAX_DATA_LEN`, 570: largest legal data-word count in the length field; must fit in WORD_WIDTH bits.
- `TRAILER_WORDS`, 2: words following the data words; ≥ 1.
- `CLK_RX`  in  1  receive clock; all logic on its rising edge.
- `RST`  in  1  reset, synchronous, active-high.
- `ENABLE`  in  1  when low, new frame starts are ignored; a frame already in progress completes.
- `MKD_RX`  in  1  serial marker.
- `DATA_RX`  in  1  serial data, LSB first.
- `WRITE`  out  1  one-cycle strobe; `DATA` is valid.
- `DATA`  out  WORD_WIDTH  completed word.
- `FRAME_START`  out  1  high with the `WRITE` of header word 0.
- `FRAME_END`  out  1  high with the `WRITE` of the last trailer word.
- `LEN_ERR`  out  1  one-cycle pulse: length field > MAX_DATA_LEN.
- `FRAME_CNT`  out  16  frames started, wraps at 0xFFFF→0.
- `ERR_CNT`  out  8  LEN_ERR plus overlap events, saturates at 255.

## Operation
- Every cycle, `DATA_RX` shifts into a WORD_WIDTH data shift register, MSB end in (LSB-first word). `MKD_RX` shifts into a WORD_WIDTH marker shift register.
- Start condition: the oldest MKD_LEN marker samples are all 1. Detect fires on the rising edge of this condition, so a marker longer than MKD_LEN produces exactly one detection. The marker therefore covers the first MKD_LEN bits of header word 0, which is fully in the shift register at detection.
- Detection is qualified by `ENABLE`=1. A qualified detection emits word 0 with `FRAME_START`, increments `FRAME_CNT`, clears the bit counter, and enters HDR.
- Bit counter counts 0..WORD_WIDTH-1. A word completes each time it reaches WORD_WIDTH-1.
- States and completed words:
  - IDLE: no writes.
  - HDR: word 1 (frame number) is written, then go to LEN.
  - LEN: word 2 is written and latched as L (unsigned). If L > MAX_DATA_LEN: pulse `LEN_ERR`, increment `ERR_CNT`, go to IDLE. No further writes for this frame. If L = 0, go to TRL; otherwise go to DAT.
  - DAT: write L words, then go to TRL.
  - TRL: write TRAILER_WORDS words. The last one carries `FRAME_END`, then go to IDLE.
- Qualified detection in any non-IDLE state:
  - Increments `ERR_CNT` (overlap).
  - Emits `FRAME_START` for the new frame and restarts at HDR.
  - The old frame gets no `FRAME_END`.
- A detection in the same cycle as the last trailer word completes: the start takes priority. This counts as overlap, and `FRAME_END` is not asserted.
- Every frame with a legal length writes exactly 3 + L + TRAILER_WORDS words.

## Timing
- All outputs are registered. Each `WRITE` appears 1 cycle after the edge that captured the word's last bit (or the detection edge, for word 0).
- Consecutive writes inside a frame are exactly WORD_WIDTH cycles apart.
- `DATA` holds its last value between writes.
- `FRAME_START`, `FRAME_END`, and `LEN_ERR` are high only in their write cycle. `LEN_ERR` coincides with the `WRITE` of word 2.
- Reset: state IDLE. `WRITE`, `FRAME_START`, `FRAME_END`, `LEN_ERR` are 0. `DATA`, `FRAME_CNT`, `ERR_CNT` are 0. Shift registers are cleared, so a marker spanning reset release cannot detect until MKD_LEN fresh 1s have been sampled.
- `RST` mid-frame aborts immediately. No further writes occur until a new start.

## Test plan
- Defaults, L=3, marker 4 cycles:
  - 8 writes, 16 cycles apart.
  - `FRAME_START` on #1 and `FRAME_END` on #8.
  - `DATA` equals the serialised words; `FRAME_CNT`=1.
- L=0: 5 writes (header, frame number, length, 2 trailer words), with `FRAME_END` on #5.
- L=571: 3 writes; `LEN_ERR` on #3; `ERR_CNT`=1. No more writes until the next marker.
- New marker after 4 data words of an L=10 frame:
  - 7 writes so far for the old frame, with no `FRAME_END`.
  - `FRAME_START`, `ERR_CNT`=1, `FRAME_CNT`=2.
  - The new frame completes normally.
- `ENABLE`=0 at the marker: no writes and `FRAME_CNT` unchanged. `ENABLE` dropped mid-frame: the frame completes with `FRAME_END`. A 6-cycle marker gives one `FRAME_START`.
- `RST` pulsed during DAT: all outputs 0 next cycle, no further writes. The next marker starts a clean frame with `FRAME_CNT`=1.

Source files
------------

// File: rtl/m26_rx_ch_frame.sv
// m26_rx_ch_frame: one Mimosa26-style serial receiver lane.
// Deserialises DATA_RX (LSB first) and uses MKD_RX to find frame starts.
// Emits header, length, data and trailer words, flagging the frame start and end.
// Checks the length field and keeps frame and error counters.
module m26_rx_ch_frame #(
  parameter int WORD_WIDTH    = 16,
  parameter int MKD_LEN       = 4,
  parameter int MAX_DATA_LEN  = 570,
  parameter int TRAILER_WORDS = 2
) (
  input  logic                  CLK_RX,
  input  logic                  RST,
  input  logic                  ENABLE,
  input  logic                  MKD_RX,
  input  logic                  DATA_RX,
  output logic                  WRITE,
  output logic [WORD_WIDTH-1:0] DATA,
  output logic                  FRAME_START,
  output logic                  FRAME_END,
  output logic                  LEN_ERR,
  output logic [15:0]           FRAME_CNT,
  output logic [7:0]            ERR_CNT
);

  localparam int CW = $clog2(WORD_WIDTH);
  localparam logic [CW-1:0]         BIT_LAST = CW'(WORD_WIDTH - 1);
  localparam logic [CW-1:0]         ONE_C    = CW'(1);
  localparam logic [WORD_WIDTH-1:0] LEN_MAX  = WORD_WIDTH'(MAX_DATA_LEN);
  localparam logic [WORD_WIDTH-1:0] TRL_LEN  = WORD_WIDTH'(TRAILER_WORDS);
  localparam logic [WORD_WIDTH-1:0] ONE_W    = WORD_WIDTH'(1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_LEN  = 3'd2,
    ST_DAT  = 3'd3,
    ST_TRL  = 3'd4
  } state_t;

  state_t                state_r, state_nxt_s;
  logic [WORD_WIDTH-1:0] data_sr_r, mkd_sr_r;
  logic                  start_prev_r;
  logic                  start_cond_s, detect_s, word_done_s;
  logic [CW-1:0]         bit_cnt_r, bit_cnt_nxt_s;
  logic [WORD_WIDTH-1:0] rem_r, rem_nxt_s;
  logic                  write_r, write_nxt_s;
  logic [WORD_WIDTH-1:0] data_r, data_nxt_s;
  logic                  fstart_r, fstart_nxt_s;
  logic                  fend_r, fend_nxt_s;
  logic                  lerr_r, lerr_nxt_s;
  logic                  frame_inc_s, err_inc_s;
  logic [15:0]           frame_cnt_r;
  logic [7:0]            err_cnt_r;

  // The oldest MKD_LEN marker samples sit at the LSB end of the marker register.
  assign start_cond_s = &mkd_sr_r[MKD_LEN-1:0];
  assign detect_s     = start_cond_s & ~start_prev_r;
  assign word_done_s  = (bit_cnt_r == BIT_LAST);

  // Serial data and marker shift in at the MSB end; the start condition is remembered for edge detection.
  always_ff @(posedge CLK_RX) begin
    if (RST) begin
      data_sr_r    <= '0;
      mkd_sr_r     <= '0;
      start_prev_r <= 1'b0;
    end else begin
      data_sr_r    <= {DATA_RX, data_sr_r[WORD_WIDTH-1:1]};
      mkd_sr_r     <= {MKD_RX, mkd_sr_r[WORD_WIDTH-1:1]};
      start_prev_r <= start_cond_s;
    end
  end

  // Frame sequencing: a qualified start beats every other action, including a completing trailer word.
  always_comb begin
    state_nxt_s   = state_r;
    bit_cnt_nxt_s = word_done_s ? '0 : bit_cnt_r + ONE_C;
    rem_nxt_s     = rem_r;
    write_nxt_s   = 1'b0;
    data_nxt_s    = data_r;
    fstart_nxt_s  = 1'b0;
    fend_nxt_s    = 1'b0;
    lerr_nxt_s    = 1'b0;
    frame_inc_s   = 1'b0;
    err_inc_s     = 1'b0;
    if (detect_s && ENABLE) begin
      write_nxt_s   = 1'b1;
      data_nxt_s    = data_sr_r;
      fstart_nxt_s  = 1'b1;
      frame_inc_s   = 1'b1;
      err_inc_s     = (state_r != ST_IDLE);
      bit_cnt_nxt_s = '0;
      state_nxt_s   = ST_HDR;
    end else if (word_done_s) begin
      case (state_r)
        ST_IDLE: begin
          state_nxt_s = ST_IDLE;
        end
        ST_HDR: begin
          write_nxt_s = 1'b1;
          data_nxt_s  = data_sr_r;
          state_nxt_s = ST_LEN;
        end
        ST_LEN: begin
          write_nxt_s = 1'b1;
          data_nxt_s  = data_sr_r;
          if (data_sr_r > LEN_MAX) begin
            lerr_nxt_s  = 1'b1;
            err_inc_s   = 1'b1;
            state_nxt_s = ST_IDLE;
          end else if (data_sr_r == '0) begin
            rem_nxt_s   = TRL_LEN;
            state_nxt_s = ST_TRL;
          end else begin
            rem_nxt_s   = data_sr_r;
            state_nxt_s = ST_DAT;
          end
        end
        ST_DAT: begin
          write_nxt_s = 1'b1;
          data_nxt_s  = data_sr_r;
          if (rem_r == ONE_W) begin
            rem_nxt_s   = TRL_LEN;
            state_nxt_s = ST_TRL;
          end else begin
            rem_nxt_s   = rem_r - ONE_W;
          end
        end
        ST_TRL: begin
          write_nxt_s = 1'b1;
          data_nxt_s  = data_sr_r;
          if (rem_r == ONE_W) begin
            fend_nxt_s  = 1'b1;
            state_nxt_s = ST_IDLE;
          end else begin
            rem_nxt_s   = rem_r - ONE_W;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // State, bit counter and remaining-word counter.
  always_ff @(posedge CLK_RX) begin
    if (RST) begin
      state_r   <= ST_IDLE;
      bit_cnt_r <= '0;
      rem_r     <= '0;
    end else begin
      state_r   <= state_nxt_s;
      bit_cnt_r <= bit_cnt_nxt_s;
      rem_r     <= rem_nxt_s;
    end
  end

  // Registered outputs; frame count wraps, error count saturates.
  always_ff @(posedge CLK_RX) begin
    if (RST) begin
      write_r     <= 1'b0;
      data_r      <= '0;
      fstart_r    <= 1'b0;
      fend_r      <= 1'b0;
      lerr_r      <= 1'b0;
      frame_cnt_r <= 16'd0;
      err_cnt_r   <= 8'd0;
    end else begin
      write_r  <= write_nxt_s;
      data_r   <= data_nxt_s;
      fstart_r <= fstart_nxt_s;
      fend_r   <= fend_nxt_s;
      lerr_r   <= lerr_nxt_s;
      if (frame_inc_s) begin
        frame_cnt_r <= frame_cnt_r + 16'd1;
      end
      if (err_inc_s && (err_cnt_r != 8'hFF)) begin
        err_cnt_r <= err_cnt_r + 8'd1;
      end
    end
  end

  assign WRITE       = write_r;
  assign DATA        = data_r;
  assign FRAME_START = fstart_r;
  assign FRAME_END   = fend_r;
  assign LEN_ERR     = lerr_r;
  assign FRAME_CNT   = frame_cnt_r;
  assign ERR_CNT     = err_cnt_r;

endmodule

// File: tb/tb_m26_rx_ch_frame.sv
// Bench for m26_rx_ch_frame: builds a per-cycle serial stimulus from a list of frames,
// predicts every output per cycle from frame-level rules, and compares each cycle.
module tb_m26_rx_ch_frame;

  localparam int N      = 15000;
  localparam int MAXLEN = 570;
  localparam int MAXFR  = 128;

  logic        CLK_RX = 1'b0;
  logic        RST, ENABLE, MKD_RX, DATA_RX;
  logic        WRITE, FRAME_START, FRAME_END, LEN_ERR;
  logic [15:0] DATA, FRAME_CNT;
  logic [7:0]  ERR_CNT;

  m26_rx_ch_frame dut (
    .CLK_RX(CLK_RX), .RST(RST), .ENABLE(ENABLE), .MKD_RX(MKD_RX), .DATA_RX(DATA_RX),
    .WRITE(WRITE), .DATA(DATA), .FRAME_START(FRAME_START), .FRAME_END(FRAME_END),
    .LEN_ERR(LEN_ERR), .FRAME_CNT(FRAME_CNT), .ERR_CNT(ERR_CNT)
  );

  always #5 CLK_RX = ~CLK_RX;

  // Stimulus per cycle
  bit mkd_a[N];
  bit dat_a[N];
  bit en_a[N];
  bit rst_a[N];
  // Expected outputs after each edge
  bit          ew[N];
  bit          efs[N];
  bit          efe[N];
  bit          ele[N];
  logic [15:0] ewd[N];
  logic [15:0] edata[N];
  logic [15:0] efc[N];
  logic [7:0]  eec[N];
  int          fc_ev[N];
  int          er_ev[N];

  // Frame list
  int          fr_t0[$];
  int          fr_n[$];
  int          fr_base[$];
  bit          fr_le[$];
  logic [15:0] wmem[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, obs, exp);
    end
  endtask

  // Places one frame: header word 0 starts at cycle t0, marker covers its first ml bits.
  task automatic add_frame(input int t0, input int len, input int ml);
    int          n;
    bit          le;
    logic [15:0] w;
    le = (len > MAXLEN);
    n  = le ? 3 : 3 + len + 2;
    fr_t0.push_back(t0);
    fr_n.push_back(n);
    fr_le.push_back(le);
    fr_base.push_back(wmem.size());
    for (int k = 0; k < n; k++) begin
      if (k == 2) w = 16'(len);
      else        w = 16'($urandom);
      wmem.push_back(w);
      for (int b = 0; b < 16; b++) dat_a[t0 + 16*k + b] = w[b];
    end
    for (int m = 0; m < ml; m++) mkd_a[t0 + m] = 1'b1;
  endtask

  // Frame-level prediction: accept, truncate by overlap or reset, then sweep counters.
  task automatic build_model();
    int kend[MAXFR];
    bit acc[MAXFR];
    int prev, d, e, c;
    int fc, ec;
    logic [15:0] dv;
    prev = -1;
    for (int i = 0; i < fr_t0.size(); i++) begin
      d = fr_t0[i] + 16;
      acc[i] = en_a[d] && !rst_a[d];
      kend[i] = -1;
      if (acc[i]) begin
        e = d + 16*(fr_n[i] - 1);
        for (int r = d + 1; r <= e; r++) begin
          if (rst_a[r]) begin
            e = r - 1;
            break;
          end
        end
        if (prev >= 0 && kend[prev] >= d) begin
          er_ev[d]++;
          kend[prev] = d - 1;
        end
        fc_ev[d]++;
        kend[i] = e;
        prev = i;
      end
    end
    for (int i = 0; i < fr_t0.size(); i++) begin
      if (acc[i]) begin
        d = fr_t0[i] + 16;
        for (int k = 0; k < fr_n[i]; k++) begin
          c = d + 16*k;
          if (c <= kend[i]) begin
            ew[c]  = 1'b1;
            ewd[c] = wmem[fr_base[i] + k];
            efs[c] = (k == 0);
            efe[c] = (k == fr_n[i] - 1) && !fr_le[i];
            ele[c] = fr_le[i] && (k == 2);
            if (fr_le[i] && k == 2) er_ev[c]++;
          end
        end
      end
    end
    fc = 0; ec = 0; dv = 16'd0;
    for (int t = 0; t < N; t++) begin
      if (rst_a[t]) begin
        fc = 0; ec = 0; dv = 16'd0;
      end else begin
        fc = (fc + fc_ev[t]) % 65536;
        ec = ec + er_ev[t];
        if (ec > 255) ec = 255;
        if (ew[t]) dv = ewd[t];
      end
      efc[t]   = 16'(fc);
      eec[t]   = 8'(ec);
      edata[t] = dv;
    end
  endtask

  initial begin
    int cursor, len, ml, n;
    for (int c = 0; c < N; c++) begin
      dat_a[c] = 1'($urandom);
      en_a[c]  = 1'b1;
    end
    for (int c = 0; c < 5; c++) rst_a[c] = 1'b1;
    add_frame(20,   3,   4);                         // basic frame, 8 words
    add_frame(200,  0,   4);                         // empty data section
    add_frame(320,  571, 4);                         // oversize length
    add_frame(420,  10,  4);                         // cut after 4 data words
    add_frame(532,  2,   4);                         // overlapping start
    add_frame(700,  1,   4);                         // start while disabled
    for (int c = 690; c <= 760; c++) en_a[c] = 1'b0;
    add_frame(800,  5,   6);                         // long marker, enable drops mid-frame
    for (int c = 860; c <= 950; c++) en_a[c] = 1'b0;
    add_frame(1000, 8,   4);                         // reset during data words
    rst_a[1103] = 1'b1;
    add_frame(1230, 2,   4);                         // clean frame after reset
    add_frame(1400, 1,   4);                         // start lands on last trailer word
    add_frame(1480, 0,   5);
    add_frame(1600, MAXLEN, 4);                      // largest legal length
    cursor = 10900;
    while (cursor < N - 400) begin
      len = ($urandom_range(0, 5) == 0) ? int'($urandom_range(571, 65535)) : int'($urandom_range(0, 12));
      ml  = int'($urandom_range(4, 8));
      add_frame(cursor, len, ml);
      n = fr_n[fr_n.size() - 1];
      if (n >= 5 && $urandom_range(0, 2) == 0) cursor += 16 * int'($urandom_range(3, n - 1));
      else                                     cursor += 16 * n + int'($urandom_range(20, 60));
    end
    build_model();

    for (int c = 0; c < N; c++) begin
      RST     = rst_a[c];
      ENABLE  = en_a[c];
      MKD_RX  = mkd_a[c];
      DATA_RX = dat_a[c];
      @(posedge CLK_RX);
      #1;
      cyc = c;
      check_value("write",       32'(WRITE),       32'(ew[c]));
      check_value("data",        32'(DATA),        32'(edata[c]));
      check_value("frame_start", 32'(FRAME_START), 32'(efs[c]));
      check_value("frame_end",   32'(FRAME_END),   32'(efe[c]));
      check_value("len_err",     32'(LEN_ERR),     32'(ele[c]));
      check_value("frame_cnt",   32'(FRAME_CNT),   32'(efc[c]));
      check_value("err_cnt",     32'(ERR_CNT),     32'(eec[c]));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
